lcd_host: RTL and testbench

- Host-side counterpart of the LCD controller interface. Plays all three external roles the controller talks to:
  - Image ROM responder: serves the 8x8 image over IROM_rd/IROM_A/IROM_Q.
  - Command issuer: drives cmd/cmd_valid against busy from a preloaded command queue.
  - Image RAM sink: captures IRAM_valid/IRAM_A/IRAM_D writes and reports count and checksum.
- Used as the system-level driver and scoreboard endpoint for the controller.

---
 rtl/lcd_host_if.sv | 24 ++
 rtl/lcd_host.sv | 225 ++++++++++++++++++++++
 tb/tb_lcd_host.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_host_if.sv
// Controller-facing bundle of the LCD host: image ROM reads, command handshake and image RAM writes.
// The host takes the master view; the controller (or a bench standing in for it) takes the slave view.
interface lcd_host_if;
    logic       IROM_rd;
    logic [5:0] IROM_A;
    logic [7:0] IROM_Q;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       busy;
    logic       done;
    logic       IRAM_valid;
    logic [5:0] IRAM_A;
    logic [7:0] IRAM_D;

    modport master (
        input  IROM_rd, IROM_A, busy, done, IRAM_valid, IRAM_A, IRAM_D,
        output IROM_Q, cmd, cmd_valid
    );

    modport slave (
        output IROM_rd, IROM_A, busy, done, IRAM_valid, IRAM_A, IRAM_D,
        input  IROM_Q, cmd, cmd_valid
    );
endinterface

// File: rtl/lcd_host.sv
// Host-side endpoint for the LCD controller: serves the image ROM, issues queued commands
// against busy, and captures image RAM writes with a running count and checksum.
module lcd_host #(
    parameter int CMD_DEPTH = 16,
    parameter int TIMEOUT   = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [5:0]       cfg_addr,
    input  logic [7:0]       cfg_wdata,
    input  logic             q_valid,
    input  logic [3:0]       q_data,
    output logic             q_ready,
    input  logic             start,
    lcd_host_if.master       bus,
    input  logic [5:0]       rd_addr,
    output logic [7:0]       rd_data,
    output logic [6:0]       wr_count,
    output logic [15:0]      checksum,
    output logic [7:0]       issued_count,
    output logic             host_done,
    output logic             timeout_err
);

    localparam int PW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        ACK,
        WAIT_DONE,
        FINISH,
        ERROR
    } state_t;

    state_t          state_q;
    logic [3:0]      cmd_q;
    logic            cmdValid_q;
    logic            fromQueue_q;
    logic [7:0]      issuedCount_q;
    logic            hostDone_q;
    logic            timeoutErr_q;
    logic [TW-1:0]   timer_q;

    logic [7:0]      img  [64];
    logic [7:0]      sink [64];
    logic [3:0]      cmdMem [CMD_DEPTH];
    logic [PW-1:0]   wrPtr_q;
    logic [PW-1:0]   rdPtr_q;
    logic [PW:0]     count_q;

    logic [6:0]      wrCount_q, wrCount_d;
    logic [15:0]     checksum_q, checksum_d;

    logic qFull, qEmpty, pushFire, popFire, startClr, timerExpired, terminating;

    assign qFull        = (count_q == (PW+1)'(CMD_DEPTH));
    assign qEmpty       = (count_q == '0);
    assign pushFire     = q_valid && !qFull && (state_q != ERROR);
    assign popFire      = (state_q == ACK) && !bus.done && bus.busy && fromQueue_q;
    assign startClr     = start && ((state_q == IDLE) || (state_q == FINISH));
    assign timerExpired = (timer_q == TW'(TIMEOUT - 1));
    assign terminating  = (cmd_q == 4'd0) || (cmd_q >= 4'd12);

    assign q_ready       = !qFull;
    assign bus.IROM_Q    = bus.IROM_rd ? img[bus.IROM_A] : 8'h00;
    assign bus.cmd       = cmd_q;
    assign bus.cmd_valid = cmdValid_q;
    assign rd_data       = sink[rd_addr];
    assign wr_count      = wrCount_q;
    assign checksum      = checksum_q;
    assign issued_count  = issuedCount_q;
    assign host_done     = hostDone_q;
    assign timeout_err   = timeoutErr_q;

    // Image and sink memories are plain storage with no reset.
    always_ff @(posedge clk) begin
        if (cfg_we && (state_q == IDLE)) begin
            img[cfg_addr] <= cfg_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.IRAM_valid) begin
            sink[bus.IRAM_A] <= bus.IRAM_D;
        end
    end

    always_ff @(posedge clk) begin
        if (pushFire) begin
            cmdMem[wrPtr_q] <= q_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (pushFire) wrPtr_q <= wrPtr_q + PW'(1);
            if (popFire)  rdPtr_q <= rdPtr_q + PW'(1);
            case ({pushFire, popFire})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // A run start clears the sink statistics and swallows a write landing in the same cycle.
    always_comb begin
        wrCount_d  = wrCount_q;
        checksum_d = checksum_q;
        if (startClr) begin
            wrCount_d  = '0;
            checksum_d = '0;
        end else if (bus.IRAM_valid) begin
            if (wrCount_q != 7'h7F) wrCount_d = wrCount_q + 7'd1;
            checksum_d = checksum_q + {8'h00, bus.IRAM_D};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrCount_q  <= '0;
            checksum_q <= '0;
        end else begin
            wrCount_q  <= wrCount_d;
            checksum_q <= checksum_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cmd_q         <= '0;
            cmdValid_q    <= 1'b0;
            fromQueue_q   <= 1'b0;
            issuedCount_q <= '0;
            hostDone_q    <= 1'b0;
            timeoutErr_q  <= 1'b0;
            timer_q       <= '0;
        end else begin
            case (state_q)
                IDLE, FINISH: begin
                    timer_q <= '0;
                    if (start) begin
                        issuedCount_q <= '0;
                        hostDone_q    <= 1'b0;
                        state_q       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.done) begin
                        state_q    <= FINISH;
                        cmdValid_q <= 1'b0;
                        hostDone_q <= 1'b1;
                        timer_q    <= '0;
                    end else if (!bus.busy) begin
                        // An empty queue falls back to command 0, the auto-write.
                        cmd_q       <= qEmpty ? 4'd0 : cmdMem[rdPtr_q];
                        fromQueue_q <= !qEmpty;
                        cmdValid_q  <= 1'b1;
                        state_q     <= ACK;
                        timer_q     <= '0;
                    end else if (timerExpired) begin
                        state_q      <= ERROR;
                        timeoutErr_q <= 1'b1;
                        cmdValid_q   <= 1'b0;
                        timer_q      <= '0;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ACK: begin
                    if (bus.done) begin
                        state_q    <= FINISH;
                        cmdValid_q <= 1'b0;
                        hostDone_q <= 1'b1;
                        timer_q    <= '0;
                    end else if (bus.busy) begin
                        cmdValid_q <= 1'b0;
                        if (issuedCount_q != 8'hFF) issuedCount_q <= issuedCount_q + 8'd1;
                        state_q    <= terminating ? WAIT_DONE : ISSUE;
                        timer_q    <= '0;
                    end else if (timerExpired) begin
                        state_q      <= ERROR;
                        timeoutErr_q <= 1'b1;
                        cmdValid_q   <= 1'b0;
                        timer_q      <= '0;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (bus.done) begin
                        state_q    <= FINISH;
                        hostDone_q <= 1'b1;
                        timer_q    <= '0;
                    end else if (timerExpired) begin
                        state_q      <= ERROR;
                        timeoutErr_q <= 1'b1;
                        cmdValid_q   <= 1'b0;
                        timer_q      <= '0;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ERROR: begin
                    cmdValid_q   <= 1'b0;
                    timeoutErr_q <= 1'b1;
                    timer_q      <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    timer_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_host.sv
// Bench for lcd_host: stands in for the LCD controller; a negedge monitor checks each new
// command window and each ROM read against queues of expected values filled by the stimulus.
module tb_lcd_host;
    localparam int DEPTH = 16;
    localparam int TMO   = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [5:0]  cfg_addr;
    logic [7:0]  cfg_wdata;
    logic        q_valid;
    logic [3:0]  q_data;
    logic        q_ready;
    logic        start;
    logic [5:0]  rd_addr;
    logic [7:0]  rd_data;
    logic [6:0]  wr_count;
    logic [15:0] checksum;
    logic [7:0]  issued_count;
    logic        host_done;
    logic        timeout_err;

    lcd_host_if bus();

    lcd_host #(.CMD_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .q_valid      (q_valid),
        .q_data       (q_data),
        .q_ready      (q_ready),
        .start        (start),
        .bus          (bus),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .wr_count     (wr_count),
        .checksum     (checksum),
        .issued_count (issued_count),
        .host_done    (host_done),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int         vecCount  = 0;
    int         missCount = 0;
    logic [3:0] expCmdQ[$];
    logic [7:0] romExpQ[$];
    logic       prevValid = 1'b0;
    logic [3:0] monCmd;
    logic [7:0] monRom;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of queue / IRAM / start stimulus, released afterwards.
    task automatic applyStimulus(input logic qv, input logic [3:0] qd, input logic iv,
                                 input logic [5:0] ia, input logic [7:0] id, input logic st);
        q_valid        = qv;
        q_data         = qd;
        bus.IRAM_valid = iv;
        bus.IRAM_A     = ia;
        bus.IRAM_D     = id;
        start          = st;
        tick();
        q_valid        = 1'b0;
        bus.IRAM_valid = 1'b0;
        start          = 1'b0;
    endtask

    // Controller model: wait for a command, hold it a cycle, raise busy, expect the drop.
    task automatic controllerAccept();
        int n = 0;
        while (bus.cmd_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("cmd_valid_seen", bus.cmd_valid, 1);
        if (bus.cmd_valid === 1'b1) begin
            tick();
            checkOutput("cmd_valid_hold", bus.cmd_valid, 1);
            bus.busy = 1'b1;
            tick();
            checkOutput("cmd_valid_drop", bus.cmd_valid, 0);
            bus.busy = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (bus.cmd_valid === 1'b1 && !prevValid) begin
            if (expCmdQ.size() == 0) begin
                vecCount++;
                missCount++;
                $display("[TB] FAIL unexpected_cmd: got cmd %0d, expected no command", bus.cmd);
            end else begin
                monCmd = expCmdQ.pop_front();
                checkOutput("cmd", {28'd0, bus.cmd}, {28'd0, monCmd});
            end
        end
        prevValid = (bus.cmd_valid === 1'b1);
        if (romExpQ.size() != 0) begin
            monRom = romExpQ.pop_front();
            checkOutput("IROM_Q", {24'd0, bus.IROM_Q}, {24'd0, monRom});
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        q_valid = 1'b0; q_data = '0; start = 1'b0; rd_addr = '0;
        bus.IROM_rd = 1'b0; bus.IROM_A = '0; bus.busy = 1'b0; bus.done = 1'b0;
        bus.IRAM_valid = 1'b0; bus.IRAM_A = '0; bus.IRAM_D = '0;
        tick(); tick();
        reset = 1'b0;

        checkOutput("rst_cmd", {28'd0, bus.cmd}, 0);
        checkOutput("rst_cmd_valid", bus.cmd_valid, 0);
        checkOutput("rst_q_ready", q_ready, 1);
        checkOutput("rst_wr_count", wr_count, 0);
        checkOutput("rst_checksum", checksum, 0);
        checkOutput("rst_issued", issued_count, 0);
        checkOutput("rst_host_done", host_done, 0);
        checkOutput("rst_timeout_err", timeout_err, 0);

        // Image preload and ROM sweep
        for (int i = 0; i < 64; i++) begin
            cfg_we = 1'b1; cfg_addr = 6'(i); cfg_wdata = 8'(i);
            tick();
        end
        cfg_we = 1'b0;
        bus.IROM_rd = 1'b1;
        for (int a = 0; a < 64; a++) begin
            bus.IROM_A = 6'(a);
            romExpQ.push_back(8'(a));
            tick();
        end
        bus.IROM_rd = 1'b0; bus.IROM_A = 6'd7;
        romExpQ.push_back(8'd0);
        tick();

        // Queued commands 1,3,5,0
        applyStimulus(1'b1, 4'd1, 1'b0, '0, '0, 1'b0);
        applyStimulus(1'b1, 4'd3, 1'b0, '0, '0, 1'b0);
        applyStimulus(1'b1, 4'd5, 1'b0, '0, '0, 1'b0);
        applyStimulus(1'b1, 4'd0, 1'b0, '0, '0, 1'b0);
        expCmdQ.push_back(4'd1); expCmdQ.push_back(4'd3);
        expCmdQ.push_back(4'd5); expCmdQ.push_back(4'd0);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
        for (int k = 0; k < 4; k++) controllerAccept();
        checkOutput("q4_issued", issued_count, 4);
        checkOutput("q4_host_done_waiting", host_done, 0);
        tick();
        checkOutput("q4_no_new_cmd", bus.cmd_valid, 0);
        bus.done = 1'b1; tick(); bus.done = 1'b0;
        checkOutput("q4_host_done", host_done, 1);

        // Empty queue: auto-write, then sink capture
        expCmdQ.push_back(4'd0);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
        checkOutput("auto_clear_host_done", host_done, 0);
        controllerAccept();
        checkOutput("auto_issued", issued_count, 1);
        bus.done = 1'b1; tick(); bus.done = 1'b0;
        for (int a = 0; a < 64; a++) applyStimulus(1'b0, '0, 1'b1, 6'(a), 8'(a), 1'b0);
        checkOutput("sink_wr_count", wr_count, 64);
        checkOutput("sink_checksum", checksum, 2016);
        checkOutput("sink_host_done", host_done, 1);
        rd_addr = 6'd63; #1;
        checkOutput("sink_rd63", rd_data, 63);
        applyStimulus(1'b0, '0, 1'b1, 6'd63, 8'd1, 1'b0);
        checkOutput("overwrite_wr_count", wr_count, 65);
        checkOutput("overwrite_checksum", checksum, 2017);
        checkOutput("overwrite_rd63", rd_data, 1);
        for (int a = 0; a < 70; a++) applyStimulus(1'b0, '0, 1'b1, 6'd0, 8'd0, 1'b0);
        checkOutput("sat_wr_count", wr_count, 127);
        checkOutput("sat_checksum", checksum, 2017);

        // Start colliding with a write, then reset while in ACK
        expCmdQ.push_back(4'd0);
        applyStimulus(1'b0, '0, 1'b1, 6'd10, 8'h55, 1'b1);
        checkOutput("clash_wr_count", wr_count, 0);
        checkOutput("clash_checksum", checksum, 0);
        rd_addr = 6'd10; #1;
        checkOutput("clash_rd10", rd_data, 8'h55);
        tick();
        checkOutput("ack_cmd_valid", bus.cmd_valid, 1);
        applyStimulus(1'b1, 4'd4, 1'b0, '0, '0, 1'b0);
        applyStimulus(1'b1, 4'd6, 1'b0, '0, '0, 1'b0);
        reset = 1'b1; tick(); reset = 1'b0;
        checkOutput("mid_rst_cmd_valid", bus.cmd_valid, 0);
        checkOutput("mid_rst_q_ready", q_ready, 1);
        checkOutput("mid_rst_issued", issued_count, 0);
        checkOutput("mid_rst_wr_count", wr_count, 0);
        checkOutput("mid_rst_host_done", host_done, 0);

        // Fill past depth; 17th push dropped
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, (i == 16) ? 4'd9 : 4'd2, 1'b0, '0, '0, 1'b0);
            if (i == 14) checkOutput("full_q_ready_15", q_ready, 1);
            if (i == 15) checkOutput("full_q_ready_16", q_ready, 0);
            if (i == 16) checkOutput("full_q_ready_17", q_ready, 0);
        end
        for (int i = 0; i < 16; i++) expCmdQ.push_back(4'd2);
        expCmdQ.push_back(4'd0);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
        controllerAccept();
        checkOutput("full_q_ready_after_pop", q_ready, 1);
        for (int i = 0; i < 16; i++) controllerAccept();
        checkOutput("full_issued", issued_count, 17);
        bus.done = 1'b1; tick(); bus.done = 1'b0;
        checkOutput("full_host_done", host_done, 1);

        // Timeout with busy stuck high; cfg write outside IDLE ignored
        bus.busy = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
        cfg_we = 1'b1; cfg_addr = 6'd5; cfg_wdata = 8'hAA;
        tick();
        cfg_we = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        checkOutput("tmo_err_before", timeout_err, 0);
        checkOutput("tmo_cmd_valid", bus.cmd_valid, 0);
        tick();
        checkOutput("tmo_err_at", timeout_err, 1);
        bus.busy = 1'b0;
        tick(); tick(); tick();
        checkOutput("tmo_err_sticky", timeout_err, 1);
        checkOutput("tmo_cmd_valid_err", bus.cmd_valid, 0);
        reset = 1'b1; tick(); reset = 1'b0;
        checkOutput("tmo_err_cleared", timeout_err, 0);
        bus.IROM_rd = 1'b1; bus.IROM_A = 6'd5;
        romExpQ.push_back(8'd5);
        tick();
        bus.IROM_rd = 1'b0;

        // done while in ISSUE jumps straight to FINISH
        bus.busy = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
        bus.done = 1'b1; tick(); bus.done = 1'b0; bus.busy = 1'b0;
        checkOutput("early_done_host_done", host_done, 1);
        checkOutput("early_done_cmd_valid", bus.cmd_valid, 0);
        checkOutput("early_done_issued", issued_count, 0);
        tick(); tick();

        checkOutput("cmd_queue_drained", expCmdQ.size(), 0);
        checkOutput("rom_queue_drained", romExpQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end
endmodule
